matrix_operand_addr_gen: RTL and testbench

- Parametrised successor of the A-operand address generator for the systolic matrix multiplier (C[m x p] = A[m x n] * B[n x p]).
- Serves either operand buffer through a mode input (A row-block or B column-block walk).
- Emits one read address per accepted beat on a valid/ready handshake; supports stall and base offset; latches dimensions at start.
- Sits between the config module and the operand buffer read port.

---
 rtl/matrix_mult_pkg.sv | 8 +
 rtl/nested_loop_counter.sv | 34 +++
 rtl/matrix_operand_addr_gen.sv | 124 ++++++++++++
 tb/tb_matrix_operand_addr_gen.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/matrix_mult_pkg.sv
// matrix_mult_pkg: shared FSM/mode types and dimension helpers for the matrix multiplier address path
package matrix_mult_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} addr_gen_state_e;
  typedef enum logic {OPERAND_A, OPERAND_B} operand_mode_e;
  function automatic int log2_dim(input int v);
    return $clog2(v);
  endfunction
endpackage

// File: rtl/nested_loop_counter.sv
// nested_loop_counter: three-level r/c/k loop counter with step enable and wrap/last flags
module nested_loop_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         step,
  input  logic [W-1:0] r_cnt,
  input  logic [W-1:0] c_cnt,
  input  logic [W-1:0] k_cnt,
  output logic         k_wrap,
  output logic         c_wrap,
  output logic         last
);
  logic [W-1:0] r, c, k;
  assign k_wrap = k == k_cnt - W'(1);
  assign c_wrap = k_wrap && c == c_cnt - W'(1);
  assign last = c_wrap && r == r_cnt - W'(1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r <= '0;
      c <= '0;
      k <= '0;
    end else if (clear) begin
      r <= '0;
      c <= '0;
      k <= '0;
    end else if (step) begin
      k <= k_wrap ? '0 : k + W'(1);
      if (k_wrap) c <= c_wrap ? '0 : c + W'(1);
      if (c_wrap) r <= last ? '0 : r + W'(1);
    end
endmodule

// File: rtl/matrix_operand_addr_gen.sv
// matrix_operand_addr_gen: A row-block / B column-block operand address walker with valid/ready handshake.
// Defining MATRIX_ADDR_GEN_STALL_CNT_EN adds a saturating stall counter output stall_cnt_o.
module matrix_operand_addr_gen
  import matrix_mult_pkg::*;
#(
  parameter int ARRAY_HEIGHT = 4,
  parameter int ARRAY_WIDTH = 4,
  parameter int BUFFER_ADDRESS_WIDTH = 10,
  parameter int DIM_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start_i,
  input  logic                            mode_i,
  input  logic [DIM_WIDTH-1:0]            m,
  input  logic [DIM_WIDTH-1:0]            n,
  input  logic [DIM_WIDTH-1:0]            p,
  input  logic [BUFFER_ADDRESS_WIDTH-1:0] base_addr_i,
  output logic [BUFFER_ADDRESS_WIDTH-1:0] addr_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic                            last_o,
  output logic                            busy_o,
  output logic                            done_o
`ifdef MATRIX_ADDR_GEN_STALL_CNT_EN
  ,
  output logic [31:0]                     stall_cnt_o
`endif
);
  localparam int LOG_H = log2_dim(ARRAY_HEIGHT);
  localparam int LOG_W = log2_dim(ARRAY_WIDTH);
  localparam int AW = BUFFER_ADDRESS_WIDTH;
  addr_gen_state_e state;
  operand_mode_e mode_q;
  logic [AW-1:0] base_q, row_off, col_off, k_step, row_nxt, col_nxt, next_addr;
  logic [DIM_WIDTH-1:0] r_q, c_q, k_q, r_in, c_in;
  logic launch, accept, k_wrap, c_wrap, cnt_last;
  assign r_in = m >> LOG_H;
  assign c_in = p >> LOG_W;
  assign launch = state == IDLE && start_i;
  assign accept = state == RUN && valid_o && ready_i;
  assign last_o = valid_o && cnt_last;
  assign k_step = AW'(k_q);
  nested_loop_counter #(.W(DIM_WIDTH)) u_loops (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (launch),
    .step   (accept),
    .r_cnt  (r_q),
    .c_cnt  (c_q),
    .k_cnt  (k_q),
    .k_wrap (k_wrap),
    .c_wrap (c_wrap),
    .last   (cnt_last)
  );
  // Block offsets accumulate by K at each wrap, so no multiplier is needed.
  always_comb begin
    row_nxt = row_off + k_step;
    col_nxt = col_off + k_step;
    next_addr = c_wrap ? base_q + (mode_q == OPERAND_B ? '0 : row_nxt)
              : k_wrap ? base_q + (mode_q == OPERAND_B ? col_nxt : row_off)
              : addr_o + AW'(1);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      mode_q <= OPERAND_A;
      base_q <= '0;
      r_q <= '0;
      c_q <= '0;
      k_q <= '0;
      row_off <= '0;
      col_off <= '0;
      addr_o <= '0;
      valid_o <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          mode_q <= operand_mode_e'(mode_i);
          base_q <= base_addr_i;
          r_q <= r_in;
          c_q <= c_in;
          k_q <= n;
          row_off <= '0;
          col_off <= '0;
          addr_o <= base_addr_i;
          busy_o <= 1'b1;
          if (r_in == '0 || c_in == '0 || n == '0) state <= DONE;
          else begin
            state <= RUN;
            valid_o <= 1'b1;
          end
        end
        RUN: if (ready_i) begin
          if (cnt_last) begin
            state <= DONE;
            valid_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            addr_o <= next_addr;
            if (c_wrap) begin
              row_off <= row_nxt;
              col_off <= '0;
            end else if (k_wrap) col_off <= col_nxt;
          end
        end
        // An empty job enters DONE with done_o low and raises it one cycle later.
        DONE: if (done_o) begin
          state <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end else done_o <= 1'b1;
        default: state <= IDLE;
      endcase
    end
`ifdef MATRIX_ADDR_GEN_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) stall_cnt_o <= '0;
    else if (launch) stall_cnt_o <= '0;
    else if (state == RUN && valid_o && !ready_i && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
`endif
endmodule

// File: tb/tb_matrix_operand_addr_gen.sv
// tb_matrix_operand_addr_gen: directed and randomized jobs checked against a loop-nest address model
module tb_matrix_operand_addr_gen;
  localparam int LH = 2;
  localparam int LW = 2;
  localparam int BUDGET = 3000;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start_i = 1'b0;
  logic mode_i = 1'b0;
  logic ready_i = 1'b0;
  logic [15:0] m = '0, n = '0, p = '0;
  logic [9:0] base_addr_i = '0;
  logic [9:0] addr_o;
  logic valid_o, last_o, busy_o, done_o;
`ifdef MATRIX_ADDR_GEN_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
`endif
  int tests = 0;
  int failed = 0;
  always #5 clk = ~clk;
  matrix_operand_addr_gen #(
    .ARRAY_HEIGHT(4),
    .ARRAY_WIDTH(4),
    .BUFFER_ADDRESS_WIDTH(10),
    .DIM_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start_i(start_i),
    .mode_i(mode_i),
    .m(m),
    .n(n),
    .p(p),
    .base_addr_i(base_addr_i),
    .addr_o(addr_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .last_o(last_o),
    .busy_o(busy_o),
    .done_o(done_o)
`ifdef MATRIX_ADDR_GEN_STALL_CNT_EN
    ,
    .stall_cnt_o(stall_cnt_o)
`endif
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // One job: model builds the expected address list with plain loop arithmetic, then the
  // bench drives ready_i and compares every presented beat, the done timing and the stall count.
  task automatic run_job(input logic md, input logic [15:0] mm, input logic [15:0] nn, input logic [15:0] pp,
                         input logic [9:0] bs, input int stall_pct, input bit directed, input bit noise);
    logic [9:0] exp[$];
    int rr, cc, kk, nb, idx, cyc, stalls, hold;
    rr = int'(mm >> LH);
    cc = int'(pp >> LW);
    kk = int'(nn);
    for (int r = 0; r < rr; r++)
      for (int c = 0; c < cc; c++)
        for (int k = 0; k < kk; k++)
          exp.push_back(10'(int'(bs) + (md ? c * kk : r * kk) + k));
    nb = exp.size();
    idx = 0;
    stalls = 0;
    hold = 0;
    mode_i = md;
    m = mm;
    n = nn;
    p = pp;
    base_addr_i = bs;
    start_i = 1'b1;
    ready_i = 1'($urandom_range(1));
    @(posedge clk); #1;
    start_i = 1'b0;
    m = 16'($urandom);
    n = 16'($urandom);
    p = 16'($urandom);
    mode_i = ~md;
    base_addr_i = 10'($urandom);
    cyc = 1;
    check("first_valid", 32'(valid_o), 32'(nb > 0));
    while (done_o !== 1'b1 && cyc < BUDGET) begin
      check("valid", 32'(valid_o), 32'(idx < nb));
      check("busy", 32'(busy_o), 1);
      if (valid_o === 1'b1 && idx < nb) begin
        check("addr", 32'(addr_o), 32'(exp[idx]));
        check("last", 32'(last_o), 32'(idx == nb - 1));
      end
      ready_i = directed ? !(idx == 1 && hold < 3) : ($urandom_range(99) >= stall_pct);
      if (noise) start_i = 1'($urandom_range(1));
      if (valid_o === 1'b1) begin
        if (ready_i) idx++;
        else begin
          stalls++;
          if (idx == 1) hold++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    start_i = 1'b0;
    check("done_timeout", 32'(cyc < BUDGET), 1);
    check("beats", 32'(idx), 32'(nb));
    check("done_cycle", 32'(cyc), 32'(nb == 0 ? 2 : nb + stalls + 1));
    check("done_busy", 32'(busy_o), 1);
    check("done_valid", 32'(valid_o), 0);
`ifdef MATRIX_ADDR_GEN_STALL_CNT_EN
    check("stall_cnt", stall_cnt_o, 32'(stalls));
`endif
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done_o), 0);
    check("idle_busy", 32'(busy_o), 0);
    check("idle_valid", 32'(valid_o), 0);
  endtask
  initial begin
    @(posedge clk); #1;
    check("rst_addr", 32'(addr_o), 0);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_last", 32'(last_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
`ifdef MATRIX_ADDR_GEN_STALL_CNT_EN
    check("rst_stall", stall_cnt_o, 0);
`endif
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_job(1'b0, 16'd8, 16'd3, 16'd8, 10'd0, 0, 1'b0, 1'b0);
    run_job(1'b1, 16'd8, 16'd3, 16'd8, 10'd0, 0, 1'b0, 1'b0);
    run_job(1'b0, 16'd4, 16'd4, 16'd4, 10'd0, 0, 1'b1, 1'b0);
    run_job(1'b0, 16'd2, 16'd4, 16'd4, 10'd0, 0, 1'b0, 1'b0);
    run_job(1'b0, 16'd4, 16'd4, 16'd4, 10'd1022, 0, 1'b0, 1'b1);
    mode_i = 1'b0;
    m = 16'd16;
    n = 16'd5;
    p = 16'd16;
    base_addr_i = 10'd7;
    ready_i = 1'b1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre_reset_valid", 32'(valid_o), 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_addr", 32'(addr_o), 0);
    check("async_valid", 32'(valid_o), 0);
    check("async_last", 32'(last_o), 0);
    check("async_busy", 32'(busy_o), 0);
    check("async_done", 32'(done_o), 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_no_done", 32'(done_o), 0);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_job(1'b1, 16'd12, 16'd5, 16'd12, 10'd1000, 30, 1'b0, 1'b1);
    for (int i = 0; i < 24; i++)
      run_job(1'($urandom_range(1)), 16'($urandom_range(13)), 16'($urandom_range(5)), 16'($urandom_range(13)),
              10'($urandom), $urandom_range(60), 1'b0, 1'($urandom_range(1)));
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
